// File: rtl/alu_pkg.sv
// Shared constants for the ALU sequencer: default widths, opcode encodings and FSM state codes.
package alu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 4;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_MAX = OP_XOR;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_READ  = 2'd1;
  localparam state_t ST_EXEC  = 2'd2;
  localparam state_t ST_WRITE = 2'd3;

endpackage

// File: rtl/alu_seq_regfile.sv
// Register file for the ALU sequencer: one write port, three combinational read ports.
// R0 is hardwired to zero: writes to index 0 are dropped and reads of it return 0.
module alu_seq_regfile #(
  parameter int unsigned DATA_W = alu_pkg::DATA_W,
  parameter int unsigned REG_AW = alu_pkg::REG_AW
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [REG_AW-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b,
  input  logic [REG_AW-1:0] i_raddr_d,
  output logic [DATA_W-1:0] o_rdata_d
);
  import alu_pkg::*;

  localparam int unsigned NUM_REGS = 2 ** REG_AW;

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_regs[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_regs[i_raddr_b];
  assign o_rdata_d = (i_raddr_d == '0) ? '0 : r_regs[i_raddr_d];

endmodule

// File: rtl/alu_sequencer.sv
// Register-addressed command sequencer in front of a combinational ALU (IDLE/READ/EXEC/WRITE).
// Optional result flags (flag_z, flag_n) are built when ALU_SEQ_FLAGS_EN is defined.
module alu_sequencer #(
  parameter int unsigned DATA_W = alu_pkg::DATA_W,
  parameter int unsigned REG_AW = alu_pkg::REG_AW,
  parameter int unsigned OP_MAX = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_opcode,
  input  logic [REG_AW-1:0] cmd_rd,
  input  logic [REG_AW-1:0] cmd_rs,
  input  logic [REG_AW-1:0] cmd_rt,
  input  logic              load_en,
  input  logic [REG_AW-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [REG_AW-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [3:0]        alu_opcode,
  output logic              alu_exec,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              done,
  output logic              err
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic              flag_z,
  output logic              flag_n
`endif
);
  import alu_pkg::*;

  localparam logic [3:0] OP_LIMIT = 4'(OP_MAX);

  state_t            r_state;
  state_t            w_state_next;
  logic [3:0]        r_op;
  logic [REG_AW-1:0] r_rd;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [DATA_W-1:0] r_result;
  logic              r_illegal;
  logic              w_accept;
  logic              w_we;
  logic [REG_AW-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rs_data;
  logic [DATA_W-1:0] w_rt_data;

  assign cmd_ready = (r_state == ST_IDLE);
  assign w_accept  = cmd_valid & cmd_ready;
  assign alu_exec  = (r_state == ST_EXEC);
  assign done      = (r_state == ST_WRITE);
  assign err       = done & r_illegal;

  // Host loads and writebacks live in different states, so they never collide.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = load_addr;
    w_wdata = load_data;
    if ((r_state == ST_IDLE) && load_en) begin
      w_we = 1'b1;
    end else if ((r_state == ST_WRITE) && !r_illegal) begin
      w_we    = 1'b1;
      w_waddr = r_rd;
      w_wdata = r_result;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_next = ST_READ;
      ST_READ:  w_state_next = ST_EXEC;
      ST_EXEC:  w_state_next = ST_WRITE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_op       <= '0;
      r_rd       <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_result   <= '0;
      r_illegal  <= 1'b0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_op <= cmd_opcode;
        r_rd <= cmd_rd;
        r_rs <= cmd_rs;
        r_rt <= cmd_rt;
      end
      if (r_state == ST_READ) begin
        alu_a      <= w_rs_data;
        alu_b      <= w_rt_data;
        alu_opcode <= r_op;
      end
      if (r_state == ST_EXEC) begin
        r_result  <= alu_result;
        r_illegal <= (r_op > OP_LIMIT);
      end
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic r_flag_z;
  logic r_flag_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_flag_z <= 1'b0;
      r_flag_n <= 1'b0;
    end else if ((r_state == ST_WRITE) && !r_illegal) begin
      r_flag_z <= (r_result == '0);
      r_flag_n <= r_result[DATA_W-1];
    end
  end

  assign flag_z = r_flag_z;
  assign flag_n = r_flag_n;
`endif

  alu_seq_regfile #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (r_rs),
    .o_rdata_a (w_rs_data),
    .i_raddr_b (r_rt),
    .o_rdata_b (w_rt_data),
    .i_raddr_d (rd_addr),
    .o_rdata_d (rd_data)
  );

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: vector table plus scoreboard, with a behavioural ALU.
// Flag checks are compiled in when ALU_SEQ_FLAGS_EN is defined.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_opcode;
  logic [3:0]  cmd_rd;
  logic [3:0]  cmd_rs;
  logic [3:0]  cmd_rt;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [31:0] load_data;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic [3:0]  alu_opcode;
  logic        alu_exec;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        done;
  logic        err;
`ifdef ALU_SEQ_FLAGS_EN
  logic        flag_z;
  logic        flag_n;
`endif

  always #5 clock = ~clock;

  alu_sequencer dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_rd     (cmd_rd),
    .cmd_rs     (cmd_rs),
    .cmd_rt     (cmd_rt),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .alu_opcode (alu_opcode),
    .alu_exec   (alu_exec),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .done       (done),
    .err        (err)
`ifdef ALU_SEQ_FLAGS_EN
    ,
    .flag_z     (flag_z),
    .flag_n     (flag_n)
`endif
  );

  // Behavioural ALU; illegal opcodes return a poison value that must never be written back.
  always_comb begin
    alu_result = 32'hDEAD_BEEF;
    case (alu_opcode)
      OP_ADD: alu_result = alu_a + alu_b;
      OP_SUB: alu_result = alu_a - alu_b;
      OP_AND: alu_result = alu_a & alu_b;
      OP_OR:  alu_result = alu_a | alu_b;
      OP_XOR: alu_result = alu_a ^ alu_b;
      default: alu_result = 32'hDEAD_BEEF;
    endcase
  end

  typedef struct {
    logic [3:0]  rd;
    logic [31:0] val;
    logic        err;
    logic        fz;
    logic        fn;
    int          acc;
  } sb_t;

  typedef struct {
    bit          ld;
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [31:0] data;
    logic [31:0] res;
  } vec_t;

  sb_t         sb[$];
  sb_t         mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          exec_cnt = 0;
  bit          pend_chk = 1'b0;
  logic [31:0] pend_val;
  logic        pend_z;
  logic        pend_n;
  logic [3:0]  mon_addr = 4'd0;
  logic [3:0]  tb_addr;
  logic        last_z = 1'b0;
  logic        last_n = 1'b0;
  int          last_acc;
  int          first_acc;
  vec_t        vt[19];

  assign rd_addr = pend_chk ? mon_addr : tb_addr;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  // Monitor: pops the scoreboard on each done pulse, then checks the writeback one cycle later.
  always @(negedge clock) begin
    if (!reset_n) begin
      exec_cnt = 0;
      pend_chk = 1'b0;
    end else begin
      if (pend_chk) begin
        check("wb_value", rd_data, pend_val);
`ifdef ALU_SEQ_FLAGS_EN
        check("flag_z", {31'd0, flag_z}, {31'd0, pend_z});
        check("flag_n", {31'd0, flag_n}, {31'd0, pend_n});
`endif
        pend_chk = 1'b0;
      end
      if (alu_exec) exec_cnt++;
      if (err && !done) fail("err_without_done");
      if (done) begin
        if (sb.size() == 0) begin
          fail("unexpected_done");
        end else begin
          mon_e = sb.pop_front();
          check("err_flag", {31'd0, err}, {31'd0, mon_e.err});
          // done appears after the second edge following the accepting edge
          check("done_latency", 32'(cyc - mon_e.acc), 32'd2);
          check("exec_pulses", 32'(exec_cnt), 32'd1);
          exec_cnt = 0;
          mon_addr = mon_e.rd;
          pend_val = mon_e.val;
          pend_z   = mon_e.fz;
          pend_n   = mon_e.fn;
          pend_chk = 1'b1;
        end
      end
    end
  end

  task automatic host_load(input logic [3:0] addr, input logic [31:0] data);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    tick();
    load_en = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                       input logic [3:0] rt, input logic [31:0] val, input logic [31:0] res,
                       input bit hold);
    sb_t e;
    int  g = 0;
    cmd_opcode = op;
    cmd_rd     = rd;
    cmd_rs     = rs;
    cmd_rt     = rt;
    cmd_valid  = 1'b1;
    while (!cmd_ready && g < 20) begin
      tick();
      g++;
    end
    if (!cmd_ready) begin
      fail("accept_timeout");
      cmd_valid = 1'b0;
      return;
    end
    e.rd  = rd;
    e.val = val;
    e.err = (op > OP_MAX);
    if (!e.err) begin
      last_z = (res == 32'd0);
      last_n = res[31];
    end
    e.fz = last_z;
    e.fn = last_n;
    e.acc = cyc + 1;
    last_acc = e.acc;
    sb.push_back(e);
    tick();
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((sb.size() != 0 || pend_chk) && g < 30) begin
      tick();
      g++;
    end
    if (g >= 30) fail("idle_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1'b1, OP_ADD, 4'd1,  4'd0, 4'd0, 32'h0000_000A, 32'h0};
    vt[1]  = '{1'b1, OP_ADD, 4'd2,  4'd0, 4'd0, 32'h0000_0003, 32'h0};
    vt[2]  = '{1'b0, OP_ADD, 4'd3,  4'd1, 4'd2, 32'h0000_000D, 32'h0000_000D};
    vt[3]  = '{1'b0, OP_SUB, 4'd4,  4'd1, 4'd2, 32'h0000_0007, 32'h0000_0007};
    vt[4]  = '{1'b1, OP_ADD, 4'd1,  4'd0, 4'd0, 32'hFFFF_FFFF, 32'h0};
    vt[5]  = '{1'b1, OP_ADD, 4'd2,  4'd0, 4'd0, 32'h0000_0001, 32'h0};
    vt[6]  = '{1'b0, OP_ADD, 4'd5,  4'd1, 4'd2, 32'h0000_0000, 32'h0000_0000};
    vt[7]  = '{1'b0, OP_XOR, 4'd6,  4'd1, 4'd1, 32'h0000_0000, 32'h0000_0000};
    vt[8]  = '{1'b0, OP_OR,  4'd7,  4'd1, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vt[9]  = '{1'b0, OP_AND, 4'd10, 4'd1, 4'd2, 32'h0000_0001, 32'h0000_0001};
    vt[10] = '{1'b0, OP_SUB, 4'd11, 4'd2, 4'd1, 32'h0000_0002, 32'h0000_0002};
    vt[11] = '{1'b1, OP_ADD, 4'd8,  4'd0, 4'd0, 32'h0000_0055, 32'h0};
    vt[12] = '{1'b0, 4'd7,   4'd8,  4'd1, 4'd2, 32'h0000_0055, 32'h0};
    vt[13] = '{1'b0, 4'd5,   4'd8,  4'd1, 4'd2, 32'h0000_0055, 32'h0};
    vt[14] = '{1'b0, 4'd15,  4'd8,  4'd1, 4'd1, 32'h0000_0055, 32'h0};
    vt[15] = '{1'b0, OP_ADD, 4'd3,  4'd3, 4'd3, 32'h0000_001A, 32'h0000_001A};
    vt[16] = '{1'b1, OP_ADD, 4'd1,  4'd0, 4'd0, 32'h0000_0001, 32'h0};
    vt[17] = '{1'b1, OP_ADD, 4'd2,  4'd0, 4'd0, 32'h0000_0001, 32'h0};
    vt[18] = '{1'b0, OP_ADD, 4'd0,  4'd1, 4'd2, 32'h0000_0000, 32'h0000_0002};

    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_opcode = 4'd0;
    cmd_rd     = 4'd0;
    cmd_rs     = 4'd0;
    cmd_rt     = 4'd0;
    load_en    = 1'b0;
    load_addr  = 4'd0;
    load_data  = 32'd0;
    tb_addr    = 4'd1;
    repeat (3) @(negedge clock);
    #1;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_alu_exec", {31'd0, alu_exec}, 32'd0);
    check("rst_alu_opcode", {28'd0, alu_opcode}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_reg", rd_data, 32'd0);
    reset_n = 1'b1;
    tick();

    // Reset asserted in the middle of EXEC must abort the command.
    host_load(4'd1, 32'd5);
    host_load(4'd2, 32'd3);
    cmd_opcode = OP_ADD;
    cmd_rd     = 4'd3;
    cmd_rs     = 4'd1;
    cmd_rt     = 4'd2;
    cmd_valid  = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("busy_ready", {31'd0, cmd_ready}, 32'd0);
    tick();
    check("mid_exec", {31'd0, alu_exec}, 32'd1);
    check("mid_alu_a", alu_a, 32'd5);
    check("mid_alu_b", alu_b, 32'd3);
    reset_n = 1'b0;
    #1;
    check("arst_exec", {31'd0, alu_exec}, 32'd0);
    check("arst_ready", {31'd0, cmd_ready}, 32'd1);
    check("arst_alu_a", alu_a, 32'd0);
    check("arst_alu_b", alu_b, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    tb_addr = 4'd3;
    #1;
    check("arst_r3", rd_data, 32'd0);
    tb_addr = 4'd1;
    #1;
    check("arst_r1", rd_data, 32'd0);
    check("arst_ready_after", {31'd0, cmd_ready}, 32'd1);

    for (int i = 0; i < 19; i++) begin
      if (vt[i].ld) begin
        host_load(vt[i].rd, vt[i].data);
      end else begin
        issue(vt[i].op, vt[i].rd, vt[i].rs, vt[i].rt, vt[i].data, vt[i].res, 1'b0);
        wait_idle();
      end
    end

    host_load(4'd0, 32'h0000_0099);
    tb_addr = 4'd0;
    #1;
    check("r0_load_dropped", rd_data, 32'd0);

    // Valid held across two commands; load coincides with the first accept; busy load dropped.
    load_en   = 1'b1;
    load_addr = 4'd1;
    load_data = 32'd7;
    issue(OP_ADD, 4'd9, 4'd1, 4'd1, 32'd14, 32'd14, 1'b1);
    first_acc = last_acc;
    load_addr = 4'd13;
    load_data = 32'h0000_0077;
    check("hold_busy_ready", {31'd0, cmd_ready}, 32'd0);
    cmd_opcode = OP_XOR;
    cmd_rd     = 4'd12;
    cmd_rs     = 4'd9;
    cmd_rt     = 4'd1;
    tick();
    tick();
    load_en = 1'b0;
    issue(OP_XOR, 4'd12, 4'd9, 4'd1, 32'd9, 32'd9, 1'b0);
    check("accept_spacing", 32'(last_acc - first_acc), 32'd4);
    wait_idle();
    tb_addr = 4'd13;
    #1;
    check("busy_load_dropped", rd_data, 32'd0);
    tb_addr = 4'd1;
    #1;
    check("coincident_load", rd_data, 32'd7);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
